// File: rtl/button_conditioner.sv
// button_conditioner
//
// Conditions active-low, asynchronous pushbutton pins for use by synchronous logic.
// Each channel has its own copy of the following stages:
//   - a two-flop synchroniser
//   - a counter-based debouncer
//   - press edge detection
//   - an optional hold-to-auto-repeat FSM
// The channels share no state.
//
// Ports:
//   clock       in   system clock, all state on the rising edge
//   clear       in   asynchronous active-high reset
//   button_n_i  in   [NUM_BUTTONS] raw pins, active-low, asynchronous to clock
//   level_o     out  [NUM_BUTTONS] debounced pressed state, active-high, registered
//   press_o     out  [NUM_BUTTONS] one-cycle pulse per accepted press / repeat tick, registered

module button_conditioner #(
    parameter int unsigned NUM_BUTTONS     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [NUM_BUTTONS-1:0] button_n_i,
    output logic [NUM_BUTTONS-1:0] level_o,
    output logic [NUM_BUTTONS-1:0] press_o
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                    : REPEAT_PERIOD;
    localparam int unsigned HCNT_W = $clog2(HMAX) + 1;

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_DELAY  = HCNT_W'(REPEAT_DELAY);
    localparam logic [HCNT_W-1:0] HCNT_PERIOD = HCNT_W'(REPEAT_PERIOD);
    localparam logic [HCNT_W-1:0] HCNT_ONE    = HCNT_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StRpt
    } rpt_state_e;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        logic [1:0]        sync_q, sync_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic [DCNT_W-1:0] dcnt_q, dcnt_d;
        logic [HCNT_W-1:0] hcnt_q, hcnt_d;
        rpt_state_e        state_q, state_d;
        logic              s;
        logic              level_rise;
        logic              level_fall;

        always_comb begin
            // Invert at the pin so everything downstream is active-high.
            sync_d = {sync_q[0], ~button_n_i[i]};
            s      = sync_q[1];

            // Debounce: accept s only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
            level_d = level_q;
            dcnt_d  = '0;
            if (s != level_q) begin
                if (dcnt_q == DCNT_LAST) begin
                    level_d = s;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            level_rise = ~level_q & level_d;
            level_fall = level_q & ~level_d;

            state_d = state_q;
            hcnt_d  = hcnt_q;
            press_d = level_rise;

            case (state_q)
                StIdle: begin
                    if (level_rise) begin
                        state_d = StHeld;
                        hcnt_d  = HCNT_ONE;
                    end
                end
                StHeld: begin
                    // A release takes priority over a repeat pulse due on the same edge.
                    if (level_fall) begin
                        state_d = StIdle;
                        hcnt_d  = '0;
                    end else if (REPEAT_DELAY != 0) begin
                        if (hcnt_q == HCNT_DELAY) begin
                            press_d = 1'b1;
                            hcnt_d  = HCNT_ONE;
                            state_d = StRpt;
                        end else begin
                            hcnt_d = hcnt_q + HCNT_ONE;
                        end
                    end
                end
                StRpt: begin
                    if (level_fall) begin
                        state_d = StIdle;
                        hcnt_d  = '0;
                    end else if (hcnt_q == HCNT_PERIOD) begin
                        press_d = 1'b1;
                        hcnt_d  = HCNT_ONE;
                    end else begin
                        hcnt_d = hcnt_q + HCNT_ONE;
                    end
                end
                default: begin
                    state_d = StIdle;
                    hcnt_d  = '0;
                end
            endcase
        end

        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                sync_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                dcnt_q  <= '0;
                hcnt_q  <= '0;
                state_q <= StIdle;
            end else begin
                sync_q  <= sync_d;
                level_q <= level_d;
                press_q <= press_d;
                dcnt_q  <= dcnt_d;
                hcnt_q  <= hcnt_d;
                state_q <= state_d;
            end
        end

        assign level_o[i] = level_q;
        assign press_o[i] = press_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner.
// The reference model keeps a history of pin samples per edge and derives the expected
// outputs from the timing rules:
//   - the level flips once DEBOUNCE_CYCLES consecutive samples disagree with it
//   - press pulses come from the press edge plus the repeat arithmetic

module tb_button_conditioner;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic          clock;
    logic          clear;
    logic [NB-1:0] button_n_i;
    logic [NB-1:0] level_o;
    logic [NB-1:0] press_o;

    int tests_run = 0;
    int fails     = 0;

    // Model state: pressed samples per edge since last reset.
    bit [NB-1:0] hist[$];
    bit [NB-1:0] level_m;
    int          press_edge[NB];

    button_conditioner #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .button_n_i(button_n_i),
        .level_o   (level_o),
        .press_o   (press_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit hist_at(int ch, int k);
        if (k < 0) return 1'b0;
        return hist[k][ch];
    endfunction

    task automatic model_reset();
        hist.delete();
        level_m = '0;
        for (int c = 0; c < NB; c++) press_edge[c] = -1000000;
    endtask

    // One clock: drive pins, advance model at the edge, check outputs 1 time unit later.
    task automatic cycle(input logic [NB-1:0] pressed);
        bit [NB-1:0] exp_level;
        bit [NB-1:0] exp_press;
        int          e;
        bit          all_diff;
        int          d;
        button_n_i = ~pressed;
        @(posedge clock);
        hist.push_back(pressed);
        e = hist.size() - 1;
        for (int c = 0; c < NB; c++) begin
            all_diff = 1'b1;
            for (int k = e - DEB - 1; k <= e - 2; k++) begin
                if (hist_at(c, k) == level_m[c]) all_diff = 1'b0;
            end
            exp_level[c] = all_diff ? ~level_m[c] : level_m[c];
            exp_press[c] = 1'b0;
            if (!level_m[c] && exp_level[c]) begin
                exp_press[c]  = 1'b1;
                press_edge[c] = e;
            end else if (level_m[c] && exp_level[c] && RD > 0) begin
                d = e - press_edge[c];
                if (d >= RD && ((d - RD) % RP) == 0) exp_press[c] = 1'b1;
            end
            level_m[c] = exp_level[c];
        end
        #1;
        for (int c = 0; c < NB; c++) begin
            tests_run++;
            if (level_o[c] !== exp_level[c]) begin
                fails++;
                $display("FAIL model_level ch%0d edge %0d: got %b expected %b",
                         c, e, level_o[c], exp_level[c]);
            end
            tests_run++;
            if (press_o[c] !== exp_press[c]) begin
                fails++;
                $display("FAIL model_press ch%0d edge %0d: got %b expected %b",
                         c, e, press_o[c], exp_press[c]);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0);
    endtask

    task automatic test_reset();
        clear      = 1'b1;
        button_n_i = '1;
        #2;
        tests_run++;
        if (level_o !== '0) begin
            fails++;
            $display("FAIL reset_level: got %b expected 00", level_o);
        end
        tests_run++;
        if (press_o !== '0) begin
            fails++;
            $display("FAIL reset_press: got %b expected 00", press_o);
        end
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        model_reset();
        idle(4);
    endtask

    task automatic test_clean_press();
        int   press_cnt = 0;
        int   press_at  = -1;
        int   fall_at   = -1;
        logic prev      = level_o[0];
        for (int k = 0; k < 25; k++) begin
            cycle((k < 15) ? 2'b01 : 2'b00);
            if (press_o[0]) begin
                press_cnt++;
                press_at = k;
            end
            if (prev && !level_o[0]) fall_at = k;
            prev = level_o[0];
        end
        tests_run++;
        if (press_at != 5 || press_cnt != 1) begin
            fails++;
            $display("FAIL clean_press: got edge %0d count %0d expected edge 5 count 1",
                     press_at, press_cnt);
        end
        tests_run++;
        if (fall_at != 20) begin
            fails++;
            $display("FAIL clean_release: got edge %0d expected 20", fall_at);
        end
        idle(5);
    endtask

    task automatic test_bounce();
        int press_at  = -1;
        int early_act = 0;
        for (int k = 0; k < 40; k++) begin
            if (k < 20) cycle((((k / 2) % 2) == 0) ? 2'b01 : 2'b00);
            else if (k < 32) cycle(2'b01);
            else cycle(2'b00);
            if (k < 25 && (level_o[0] || press_o[0])) early_act++;
            if (press_o[0] && press_at < 0) press_at = k;
        end
        tests_run++;
        if (early_act != 0) begin
            fails++;
            $display("FAIL bounce_quiet: got %0d active cycles expected 0", early_act);
        end
        tests_run++;
        if (press_at != 25) begin
            fails++;
            $display("FAIL bounce_press: got edge %0d expected 25", press_at);
        end
        idle(8);
    endtask

    task automatic test_glitch();
        int act = 0;
        for (int k = 0; k < 15; k++) begin
            cycle((k < 3) ? 2'b10 : 2'b00);
            if (level_o[1] || press_o[1]) act++;
        end
        tests_run++;
        if (act != 0) begin
            fails++;
            $display("FAIL glitch_reject: got %0d active cycles expected 0", act);
        end
    endtask

    task automatic test_auto_repeat();
        int got[$];
        int exp_e[6] = '{5, 25, 33, 41, 49, 57};
        int fall_at  = -1;
        logic prev   = level_o[0];
        for (int k = 0; k < 72; k++) begin
            cycle((k < 60) ? 2'b01 : 2'b00);
            if (press_o[0]) got.push_back(k);
            if (prev && !level_o[0]) fall_at = k;
            prev = level_o[0];
        end
        tests_run++;
        if (got.size() != 6) begin
            fails++;
            $display("FAIL repeat_count: got %0d pulses expected 6", got.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                tests_run++;
                if (got[j] != exp_e[j]) begin
                    fails++;
                    $display("FAIL repeat_edge[%0d]: got %0d expected %0d", j, got[j], exp_e[j]);
                end
            end
        end
        tests_run++;
        if (fall_at != 65) begin
            fails++;
            $display("FAIL repeat_release: got edge %0d expected 65", fall_at);
        end
        idle(5);
    endtask

    task automatic test_reset_mid_hold();
        int press_at = -1;
        int rise_at  = -1;
        for (int k = 0; k < 31; k++) cycle(2'b01);
        clear = 1'b1;
        #1;
        tests_run++;
        if (level_o !== '0 || press_o !== '0) begin
            fails++;
            $display("FAIL midhold_clear: got level %b press %b expected 00 00", level_o, press_o);
        end
        @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        model_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(2'b01);
            if (press_o[0] && press_at < 0) press_at = k;
            if (level_o[0] && rise_at < 0) rise_at = k;
        end
        tests_run++;
        if (press_at != 5 || rise_at != 5) begin
            fails++;
            $display("FAIL midhold_redetect: got press %0d level %0d expected 5 5",
                     press_at, rise_at);
        end
        idle(8);
    endtask

    task automatic test_independence();
        int p0 = -1;
        int p1 = -1;
        for (int k = 0; k < 16; k++) begin
            cycle({(k >= 2) ? 1'b1 : 1'b0, 1'b1});
            if (press_o[0] && p0 < 0) p0 = k;
            if (press_o[1] && p1 < 0) p1 = k;
        end
        tests_run++;
        if (p0 != 5 || p1 != 7) begin
            fails++;
            $display("FAIL independence: got ch0 %0d ch1 %0d expected 5 7", p0, p1);
        end
        idle(8);
    endtask

    task automatic test_random();
        logic [NB-1:0] cur = '0;
        int            hold[NB];
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    cur[c]  = $urandom_range(0, 1);
                    hold[c] = $urandom_range(1, 40);
                end
                hold[c]--;
            end
            cycle(cur);
        end
        idle(8);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_reset_mid_hold();
        test_independence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
